// File: rtl/autocorr_frame_ctrl_if.sv
// Stream-in / result-out handshake bundle for the autocorrelator frame sequencer.
// The controller uses the slave view; the sample source and result consumer use master.
interface autocorr_frame_ctrl_if #(
    parameter int ACC_W = 6
);
    logic             s_valid;
    logic             s_ready;
    logic [2:0]       s_data;
    logic             m_valid;
    logic             m_ready;
    logic [ACC_W-1:0] m_lag0;
    logic [ACC_W-1:0] m_lag1;
    logic [ACC_W-1:0] m_lag2;

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_lag0, m_lag1, m_lag2
    );

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_lag0, m_lag1, m_lag2
    );
endinterface

// File: rtl/autocorr_frame_ctrl.sv
// Frame sequencer: feeds FRAME_LEN words to a free-running autocorrelator and
// accumulates its lag outputs (saturating) into one result per frame.
module autocorr_frame_ctrl #(
    parameter int FRAME_LEN = 8,
    parameter int ACC_W     = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    autocorr_frame_ctrl_if.slave io,
    output logic [2:0]           corr_in,
    input  logic [1:0]           corr_out0,
    input  logic [1:0]           corr_out1,
    input  logic [1:0]           corr_out2,
    output logic                 busy,
    output logic [7:0]           frame_cnt
);
    typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

    state_t           state, state_n;
    logic             v1, v2;
    logic             accept, last;
    logic [ACC_W-1:0] acc0, acc1, acc2;

    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a, input logic [1:0] b);
        logic [ACC_W:0] sum;
        sum = {1'b0, a} + {{(ACC_W-1){1'b0}}, b};
        return sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
    endfunction

    // Accept is derived from state directly so it does not loop through s_ready.
    assign accept = io.s_valid && (state == FEED);
    assign last   = accept && (frame_cnt == 8'(FRAME_LEN - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n     = state;
        io.s_ready  = 1'b0;
        io.m_valid  = 1'b0;
        busy        = (state != IDLE);
        case (state)
            IDLE:  if (start) state_n = FEED;
            FEED: begin
                io.s_ready = 1'b1;
                if (last) state_n = DRAIN;
            end
            DRAIN: if (!v1 && !v2) state_n = DONE;
            DONE: begin
                io.m_valid = 1'b1;
                if (io.m_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (abort) state_n = IDLE;
    end

    // v1: word sits on corr_in; v2: autocorrelator has registered that word's lags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            corr_in   <= '0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            frame_cnt <= '0;
            acc0      <= '0;
            acc1      <= '0;
            acc2      <= '0;
        end else if (abort || (state == IDLE && start)) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            frame_cnt <= '0;
            acc0      <= '0;
            acc1      <= '0;
            acc2      <= '0;
        end else begin
            v1 <= accept;
            v2 <= v1;
            if (accept) begin
                corr_in   <= io.s_data;
                frame_cnt <= frame_cnt + 8'd1;
            end
            if (v2) begin
                acc0 <= sat_add(acc0, corr_out2);
                acc1 <= sat_add(acc1, corr_out1);
                acc2 <= sat_add(acc2, corr_out0);
            end
        end
    end

    assign io.m_lag0 = acc0;
    assign io.m_lag1 = acc1;
    assign io.m_lag2 = acc2;
endmodule
